// File: rtl/cpa_resolve_pipe.sv
// Two-stage split carry-propagate adder: resolves a (sum, cout) redundant pair into
// one signed value with valid/ready flow control and a per-row last flag.
// Optional build macro CPA_SAT_EN: saturate out-of-range results instead of wrapping.
module cpa_resolve_pipe #(
  parameter int IN_W    = 11,
  parameter int OUT_W   = 13,
  parameter int BLK_LEN = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [IN_W-1:0]  in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             ovf
);

  localparam int FULL_W = IN_W + 2;
  localparam int LO_W   = FULL_W / 2;
  localparam int HI_W   = FULL_W - LO_W;
  localparam int CNT_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  // Handshake: a beat moves on a rising edge where valid and ready are both high.
  // in_ready depends combinationally on out_ready only; all other outputs are registered.
  logic              s1_v_q, s1_v_d;
  logic [LO_W-1:0]   lo_q, lo_d;
  logic              c_q, c_d;
  logic [HI_W-1:0]   hi_a_q, hi_a_d, hi_b_q, hi_b_d;
  logic              s2_v_q, s2_v_d;
  logic [FULL_W-1:0] r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              adv1, adv2, accept, out_fire;
  logic [FULL_W-1:0] op_a, op_b;
  logic [LO_W:0]     lo_sum;
  logic [HI_W-1:0]   hi_sum;
  logic              r_oor;

  // Carry vector has weight 2, so it is shifted left by one after sign extension.
  assign op_a   = {{2{in_sum[IN_W-1]}}, in_sum};
  assign op_b   = {in_cout[IN_W-1], in_cout, 1'b0};
  assign lo_sum = {1'b0, op_a[LO_W-1:0]} + {1'b0, op_b[LO_W-1:0]};
  assign hi_sum = hi_a_q + hi_b_q + {{(HI_W-1){1'b0}}, c_q};

  generate
    if (OUT_W < FULL_W) begin : g_narrow
      logic [FULL_W-OUT_W:0] top;
      logic                  fits;
      assign top   = r_q[FULL_W-1:OUT_W-1];
      assign fits  = (&top) | (~|top);
      assign r_oor = !fits;
`ifdef CPA_SAT_EN
      assign out_data = fits ? r_q[OUT_W-1:0] :
                        (r_q[FULL_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}});
`else
      assign out_data = r_q[OUT_W-1:0];
`endif
    end else begin : g_wide
      assign r_oor    = 1'b0;
      assign out_data = OUT_W'($signed(r_q));
    end
  endgenerate

  assign out_valid = s2_v_q;
  assign out_last  = s2_v_q && (cnt_q == CNT_W'(BLK_LEN - 1));
  assign ovf       = ovf_q;

  always_comb begin
    adv2     = !s2_v_q || out_ready;
    adv1     = !s1_v_q || adv2;
    in_ready = adv1;
    accept   = in_valid && adv1;
    out_fire = s2_v_q && out_ready;

    s1_v_d = adv1 ? in_valid : s1_v_q;
    lo_d   = lo_q;
    c_d    = c_q;
    hi_a_d = hi_a_q;
    hi_b_d = hi_b_q;
    if (accept) begin
      lo_d   = lo_sum[LO_W-1:0];
      c_d    = lo_sum[LO_W];
      hi_a_d = op_a[FULL_W-1:LO_W];
      hi_b_d = op_b[FULL_W-1:LO_W];
    end

    s2_v_d = adv2 ? s1_v_q : s2_v_q;
    r_d    = r_q;
    if (adv2 && s1_v_q) r_d = {hi_sum, lo_q};

    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (out_fire) begin
      cnt_d = (cnt_q == CNT_W'(BLK_LEN - 1)) ? '0 : cnt_q + 1'b1;
      if (r_oor) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      lo_q   <= '0;
      c_q    <= 1'b0;
      hi_a_q <= '0;
      hi_b_q <= '0;
      s2_v_q <= 1'b0;
      r_q    <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      lo_q   <= lo_d;
      c_q    <= c_d;
      hi_a_q <= hi_a_d;
      hi_b_q <= hi_b_d;
      s2_v_q <= s2_v_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cpa_resolve_pipe.sv
// Bench for cpa_resolve_pipe: a full-width instance (OUT_W=13) and a narrowing
// instance (OUT_W=10) share the same input stream and downstream ready.
module tb_cpa_resolve_pipe;
  localparam int IN_W   = 11;
  localparam int FULL_W = 13;
  localparam int NAR_W  = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [IN_W-1:0] in_sum = '0, in_cout = '0;

  logic             in_ready, out_valid, out_last, ovf;
  logic [FULL_W-1:0] out_data;
  logic             in_ready_n, out_valid_n, out_last_n, ovf_n;
  logic [NAR_W-1:0] out_data_n;

  cpa_resolve_pipe #(.IN_W(IN_W), .OUT_W(FULL_W), .BLK_LEN(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .ovf(ovf));

  cpa_resolve_pipe #(.IN_W(IN_W), .OUT_W(NAR_W), .BLK_LEN(8)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_sum(in_sum), .in_cout(in_cout), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_data(out_data_n), .out_last(out_last_n), .ovf(ovf_n));

  int total = 0;
  int bad = 0;
  logic [FULL_W-1:0] exp_q[$];
  int out_cnt = 0;
  int n_last = 0;
  bit ovf_n_exp = 1'b0;
  bit rand_ready = 1'b0;
  bit hold_ready = 1'b1;
  logic [FULL_W-1:0] mon_r;
  int mon_rv;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_r(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c);
    return int'($signed(s)) + 2 * int'($signed(c));
  endfunction

  function automatic int narrow_model(input int r);
`ifdef CPA_SAT_EN
    if (r > 511) return 511;
    if (r < -512) return -512;
    return r;
`else
    int w;
    w = r & 1023;
    if (w > 511) w = w - 1024;
    return w;
`endif
  endfunction

  // Downstream ready: random or held level, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
  end

  // Scoreboard: observes handshakes mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      out_cnt = 0;
      n_last = 0;
      ovf_n_exp = 1'b0;
    end else begin
      check("ovf_narrow", int'(ovf_n), int'(ovf_n_exp));
      check("valid_match", int'(out_valid_n), int'(out_valid));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mon_r = exp_q.pop_front();
          mon_rv = int'($signed(mon_r));
          check("data", int'($signed(out_data)), mon_rv);
          check("data_narrow", int'($signed(out_data_n)), narrow_model(mon_rv));
          check("last", int'(out_last), int'(out_cnt == 7));
          check("last_narrow", int'(out_last_n), int'(out_cnt == 7));
          if (mon_rv > 511 || mon_rv < -512) ovf_n_exp = 1'b1;
          if (out_last) n_last++;
          out_cnt = (out_cnt + 1) % 8;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(FULL_W'(model_r(in_sum, in_cout)));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_ready(input bit v);
    rand_ready = 1'b0;
    hold_ready = v;
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    in_sum = s;
    in_cout = c;
    in_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  typedef struct {
    int s;
    int c;
    int exp_w;
    int exp_n;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int g;
    int nv;

`ifdef CPA_SAT_EN
    vecs[0] = '{100, 7, 114, 114};
    vecs[1] = '{-1024, -1024, -3072, -512};
    vecs[2] = '{1023, 1023, 3069, 511};
    vecs[3] = '{31, 17, 65, 65};
    vecs[4] = '{1000, 100, 1200, 511};
    vecs[5] = '{-1000, -100, -1200, -512};
`else
    vecs[0] = '{100, 7, 114, 114};
    vecs[1] = '{-1024, -1024, -3072, 0};
    vecs[2] = '{1023, 1023, 3069, -3};
    vecs[3] = '{31, 17, 65, 65};
    vecs[4] = '{1000, 100, 1200, 176};
    vecs[5] = '{-1000, -100, -1200, -176};
`endif
    vecs[6] = '{0, 0, 0, 0};
    vecs[7] = '{-1, -1, -3, -3};
    vecs[8] = '{5, -3, -1, -1};

    do_reset();
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_ovf", int'(ovf_n), 0);

    // Latency: input presented in one cycle, result visible two cycles later.
    @(posedge clk);
    #1;
    in_sum = 11'd100;
    in_cout = 11'd7;
    in_valid = 1'b1;
    @(negedge clk);
    check("lat_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", int'(out_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_valid", int'(out_valid), 1);
    check("lat_data", int'($signed(out_data)), 114);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      send(IN_W'(vecs[i].s), IN_W'(vecs[i].c));
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!out_valid && g < 20);
      check($sformatf("vec%0d_valid", i), int'(out_valid), 1);
      check($sformatf("vec%0d_wide", i), int'($signed(out_data)), vecs[i].exp_w);
      check($sformatf("vec%0d_narrow", i), int'($signed(out_data_n)), vecs[i].exp_n);
      @(posedge clk);
      #1;
    end
    check("ovf_narrow_sticky", int'(ovf_n), 1);
    check("ovf_wide_clear", int'(ovf), 0);

    // Row of 16 back-to-back beats with random backpressure.
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(IN_W'($urandom_range(0, 2047)), IN_W'($urandom_range(0, 2047)));
    drain();
    check("row16_lasts", n_last, 2);

    // Reset with two beats in flight discards them and restarts the row.
    set_ready(1'b0);
    send(11'd3, 11'd4);
    send(11'd5, 11'd6);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_ready(1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(IN_W'(i * 37), IN_W'(-i));
    drain();
    check("post_rst_lasts", n_last, 1);

    // Random traffic against the arithmetic reference.
    rand_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(IN_W'($urandom_range(0, 2047)), IN_W'($urandom_range(0, 2047)));
      nv++;
    end
    drain();
    check("random_count", nv, 1000);
    check("ovf_wide_final", int'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
